uartrx_frame_parser: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 46 ++++
 rtl/uartrx_frame_timeout.sv | 32 +++
 rtl/uartrx_frame_parser.sv | 192 +++++++++++++++++++
 tb/tb_uartrx_frame_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Constants, error codes and FSM state type shared by the UART frame transmitter and parser.
// Mode byte decoding helpers live here so both sides agree on the frame format.
package uart_frame_pkg;

  localparam logic [7:0] SOF     = 8'h50;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] MODE_H1 = 8'h31;
  localparam logic [7:0] MODE_L1 = 8'h32;
  localparam logic [7:0] MODE_H3 = 8'h33;
  localparam logic [7:0] MODE_L3 = 8'h34;

  localparam logic [3:0] LEN_SHORT = 4'd4;
  localparam logic [3:0] LEN_LONG  = 4'd12;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MODE    = 2'd1;
  localparam logic [1:0] ERR_TRAILER = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MODE     = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_TRAIL_CR = 3'd3,
    ST_TRAIL_LF = 3'd4
  } rx_state_e;

  function automatic logic mode_valid(input logic [7:0] b);
    return (b == MODE_H1) || (b == MODE_L1) || (b == MODE_H3) || (b == MODE_L3);
  endfunction

  function automatic logic mode_is_long(input logic [7:0] b);
    return (b == MODE_H3) || (b == MODE_L3);
  endfunction

  function automatic logic mode_is_high(input logic [7:0] b);
    return (b == MODE_H1) || (b == MODE_H3);
  endfunction

  // Index of the final payload byte for the current frame length.
  function automatic logic [3:0] last_index(input logic is_long);
    return is_long ? (LEN_LONG - 4'd1) : (LEN_SHORT - 4'd1);
  endfunction

endpackage

// File: rtl/uartrx_frame_timeout.sv
// Inter-byte idle counter: clears on request, counts while enabled, and flags the
// cycle in which the idle run reaches TIMEOUT_CYCLES.
module uartrx_frame_timeout #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] cnt_r;

  // Idle-cycle counter; a clear request (accepted byte or idle FSM) wins over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (clear) begin
      cnt_r <= 16'd0;
    end else if (enable) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES, so a byte in that
  // same cycle (which asserts clear) still rescues the frame.
  assign expire = enable && !clear && (cnt_r == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/uartrx_frame_parser.sv
// Receive-side frame parser: recovers 'P' + mode + 4/12 payload bytes + CR LF frames
// from a UART byte stream and publishes up to three 32-bit words with status pulses.
module uartrx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rdsig,
  output logic             frame_valid,
  output logic             frame_long,
  output logic             is_high,
  output logic [31:0]      data0,
  output logic [31:0]      data1,
  output logic [31:0]      data2,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] good_cnt
);

  rx_state_e   state_r, state_n, state_d;
  logic [95:0] shadow_r, shadow_n, shadow_d;
  logic [3:0]  bcnt_r, bcnt_n, bcnt_d;
  logic        long_r, long_n;
  logic        high_r, high_n;
  logic        err_s;
  logic [1:0]  err_code_s;
  logic        publish_s;
  logic        expire_s;
  logic        to_clear_s;
  logic        to_enable_s;

  assign to_clear_s  = rdsig || (state_r == ST_IDLE);
  assign to_enable_s = (state_r != ST_IDLE);

  uartrx_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (to_clear_s),
    .enable(to_enable_s),
    .expire(expire_s)
  );

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_n    = state_r;
    shadow_n   = shadow_r;
    bcnt_n     = bcnt_r;
    long_n     = long_r;
    high_n     = high_r;
    err_s      = 1'b0;
    err_code_s = ERR_NONE;
    publish_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (rdsig && (rx_data == SOF)) begin
          state_n = ST_MODE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MODE: begin
        if (rdsig) begin
          if (mode_valid(rx_data)) begin
            state_n = ST_PAYLOAD;
            long_n  = mode_is_long(rx_data);
            high_n  = mode_is_high(rx_data);
            bcnt_n  = 4'd0;
          end else begin
            err_s      = 1'b1;
            err_code_s = ERR_MODE;
          end
        end else if (expire_s) begin
          err_s      = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else begin
          state_n = ST_MODE;
        end
      end
      ST_PAYLOAD: begin
        if (rdsig) begin
          shadow_n = {shadow_r[87:0], rx_data};
          if (bcnt_r == last_index(long_r)) begin
            state_n = ST_TRAIL_CR;
            bcnt_n  = 4'd0;
          end else begin
            bcnt_n = bcnt_r + 4'd1;
          end
        end else if (expire_s) begin
          err_s      = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else begin
          state_n = ST_PAYLOAD;
        end
      end
      ST_TRAIL_CR: begin
        if (rdsig) begin
          if (rx_data == CR) begin
            state_n = ST_TRAIL_LF;
          end else begin
            err_s      = 1'b1;
            err_code_s = ERR_TRAILER;
          end
        end else if (expire_s) begin
          err_s      = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else begin
          state_n = ST_TRAIL_CR;
        end
      end
      ST_TRAIL_LF: begin
        if (rdsig) begin
          if (rx_data == LF) begin
            state_n   = ST_IDLE;
            publish_s = 1'b1;
          end else begin
            err_s      = 1'b1;
            err_code_s = ERR_TRAILER;
          end
        end else if (expire_s) begin
          err_s      = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else begin
          state_n = ST_TRAIL_LF;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // An aborted frame flushes the datapath; a SOF as the offending byte restarts at MODE.
    state_d  = err_s ? ((rdsig && (rx_data == SOF)) ? ST_MODE : ST_IDLE) : state_n;
    shadow_d = err_s ? 96'd0 : shadow_n;
    bcnt_d   = err_s ? 4'd0 : bcnt_n;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shadow_r    <= 96'd0;
      bcnt_r      <= 4'd0;
      long_r      <= 1'b0;
      high_r      <= 1'b0;
      frame_valid <= 1'b0;
      frame_long  <= 1'b0;
      is_high     <= 1'b0;
      data0       <= 32'd0;
      data1       <= 32'd0;
      data2       <= 32'd0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      good_cnt    <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_d;
      shadow_r    <= shadow_d;
      bcnt_r      <= bcnt_d;
      long_r      <= long_n;
      high_r      <= high_n;
      frame_valid <= publish_s;
      frame_err   <= err_s;
      if (err_s) begin
        err_code <= err_code_s;
      end else begin
        err_code <= err_code;
      end
      if (publish_s) begin
        frame_long <= long_r;
        is_high    <= high_r;
        data0      <= long_r ? shadow_r[95:64] : shadow_r[31:0];
        data1      <= long_r ? shadow_r[63:32] : 32'd0;
        data2      <= long_r ? shadow_r[31:0]  : 32'd0;
        good_cnt   <= good_cnt + CNT_W'(1);
      end else begin
        frame_long <= frame_long;
        is_high    <= is_high;
        data0      <= data0;
        data1      <= data1;
        data2      <= data2;
        good_cnt   <= good_cnt;
      end
    end
  end

endmodule

// File: tb/tb_uartrx_frame_parser.sv
// Scoreboard bench for uartrx_frame_parser: expected publish/error events are queued
// with the stimulus and compared when the parser pulses frame_valid or frame_err.
module tb_uartrx_frame_parser;

  localparam logic [15:0] TO = 16'd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rdsig;
  logic        frame_valid, frame_long, is_high, frame_err;
  logic [31:0] data0, data1, data2;
  logic [1:0]  err_code;
  logic [15:0] good_cnt;

  always #5 clk = ~clk;

  uartrx_frame_parser #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rdsig(rdsig),
    .frame_valid(frame_valid), .frame_long(frame_long), .is_high(is_high),
    .data0(data0), .data1(data1), .data2(data2),
    .frame_err(frame_err), .err_code(err_code), .good_cnt(good_cnt)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    bit          lng;
    bit          hi;
    logic [31:0] d0, d1, d2;
    logic [15:0] cnt;
  } ev_t;

  ev_t         sb[$];
  logic [7:0]  bq[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model of the held output state.
  logic [15:0] m_cnt;
  logic [31:0] m_d0, m_d1, m_d2;
  logic        m_long, m_high;
  logic [1:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 16'd0; m_d0 = 32'd0; m_d1 = 32'd0; m_d2 = 32'd0;
    m_long = 1'b0; m_high = 1'b0; m_code = 2'd0;
  endtask

  task automatic push_frame(input bit lng, input bit hi, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [31:0] d2);
    ev_t e;
    m_cnt = m_cnt + 16'd1; m_long = lng; m_high = hi;
    m_d0 = d0; m_d1 = d1; m_d2 = d2;
    e.is_err = 1'b0; e.code = m_code; e.lng = lng; e.hi = hi;
    e.d0 = d0; e.d1 = d1; e.d2 = d2; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    ev_t e;
    m_code = code;
    e.is_err = 1'b1; e.code = code; e.lng = m_long; e.hi = m_high;
    e.d0 = m_d0; e.d1 = m_d1; e.d2 = m_d2; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_q();
    foreach (bq[i]) begin
      rx_data = bq[i];
      rdsig   = 1'b1;
      @(posedge clk);
      #1;
      rdsig   = 1'b0;
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_data0"}, data0, m_d0);
    chk({tag, "_data1"}, data1, m_d1);
    chk({tag, "_data2"}, data2, m_d2);
    chk({tag, "_long"}, 32'(frame_long), 32'(m_long));
    chk({tag, "_high"}, 32'(is_high), 32'(m_high));
    chk({tag, "_err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, "_good_cnt"}, 32'(good_cnt), 32'(m_cnt));
  endtask

  // Event monitor: every status pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_err)) begin
      chk("valid_err_exclusive", 32'(frame_valid & frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, frame_valid, frame_err}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_frame_err", 32'(frame_err), 32'(e.is_err));
        chk("ev_frame_valid", 32'(frame_valid), 32'(!e.is_err));
        chk("ev_err_code", 32'(err_code), 32'(e.code));
        chk("ev_frame_long", 32'(frame_long), 32'(e.lng));
        chk("ev_is_high", 32'(is_high), 32'(e.hi));
        chk("ev_data0", data0, e.d0);
        chk("ev_data1", data1, e.d1);
        chk("ev_data2", data2, e.d2);
        chk("ev_good_cnt", 32'(good_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdsig = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk_held("rst");

    // Short high frame, latency and pulse width
    push_frame(1'b0, 1'b1, 32'h12345678, 32'd0, 32'd0);
    bq = '{8'h50, 8'h31, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0D, 8'h0A};
    send_q();
    chk("short_latency", 32'(frame_valid), 32'd1);
    idle(1);
    chk("short_pulse_width", 32'(frame_valid), 32'd0);
    idle(2);

    // Long low frame
    push_frame(1'b1, 1'b0, 32'h11121314, 32'h15161718, 32'h191A1B1C);
    bq = '{8'h50, 8'h34, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
           8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h0D, 8'h0A};
    send_q();
    idle(3);

    // Bad mode leaves published outputs alone
    push_err(2'd1);
    bq = '{8'h50, 8'h35};
    send_q();
    idle(3);
    chk_held("bad_mode");

    // Bad mode then a fresh SOF
    push_err(2'd1);
    push_frame(1'b0, 1'b0, 32'hAABBCCDD, 32'd0, 32'd0);
    bq = '{8'h50, 8'h37, 8'h50, 8'h32, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0D, 8'h0A};
    send_q();
    idle(3);

    // Bad LF
    push_err(2'd2);
    bq = '{8'h50, 8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0B};
    send_q();
    idle(3);
    chk_held("bad_lf");

    // Bad CR after a long payload
    push_err(2'd2);
    bq = '{8'h50, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0A};
    send_q();
    idle(3);

    // SOF in place of LF resyncs straight into the next frame
    push_err(2'd2);
    push_frame(1'b0, 1'b1, 32'h05060708, 32'd0, 32'd0);
    bq = '{8'h50, 8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h50,
           8'h31, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0D, 8'h0A};
    send_q();
    idle(3);

    // Framing bytes are plain data inside the payload
    push_frame(1'b0, 1'b0, 32'h500D0A50, 32'd0, 32'd0);
    bq = '{8'h50, 8'h32, 8'h50, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A};
    send_q();
    idle(3);

    // Timeout after exactly TO idle cycles
    push_err(2'd3);
    bq = '{8'h50, 8'h31, 8'h01};
    send_q();
    idle(int'(TO) - 1);
    chk("timeout_not_early", 32'(frame_err), 32'd0);
    idle(1);
    chk("timeout_fires", 32'(frame_err), 32'd1);
    idle(3);
    chk_held("timeout");

    // Byte landing on the expiry cycle keeps the frame alive
    push_frame(1'b0, 1'b1, 32'h01020304, 32'd0, 32'd0);
    bq = '{8'h50, 8'h31, 8'h01};
    send_q();
    idle(int'(TO) - 1);
    bq = '{8'h02, 8'h03, 8'h04, 8'h0D, 8'h0A};
    send_q();
    idle(3);

    // Reset mid-frame
    bq = '{8'h50, 8'h33, 8'h01, 8'h02};
    send_q();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    chk("midrst_err", 32'(frame_err), 32'd0);
    chk_held("midrst");
    push_frame(1'b0, 1'b0, 32'hCAFEF00D, 32'd0, 32'd0);
    bq = '{8'h50, 8'h32, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0D, 8'h0A};
    send_q();
    idle(3);
    chk_held("post_rst");

    idle(5);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
